spmv_row_sequencer: RTL and testbench

// Sequential controller downstream of the combinational CSR row multiplier.
// - Steps row_index through rows 0..N-1 and waits SETTLE cycles for the multiplier output to settle.
// - Samples row_output and buffers {row, value} pairs in a FIFO.
// - Streams the pairs out on a valid/ready interface and gives a one-cycle done pulse per matrix pass.

---
 rtl/spmv_row_sequencer.sv | 119 +++++++++++
 tb/tb_spmv_row_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spmv_row_sequencer.sv
// Row sequencer for a combinational CSR row multiplier: steps row_index, samples
// each settled result into a small FIFO and streams {row, value} pairs out with a done pulse per pass.
module spmv_row_sequencer #(
    parameter int N          = 4,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int SETTLE     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [31:0]       row_index,
    output logic              mul_hold,
    input  logic [DATA_W-1:0] row_output,
    output logic [DATA_W-1:0] out_data,
    output logic [31:0]       out_row,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [2:0]        state_dbg
);

    // Handshake: a beat transfers on any rising edge where out_valid && out_ready;
    // out_data/out_row are held unchanged while out_valid=1 and out_ready=0.

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_CAPTURE = 3'd2,
        S_DRAIN   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t            state, state_nx;
    logic [SW-1:0]     settle_cnt;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
    logic [31:0]       mem_row  [FIFO_DEPTH];
    logic              push, pop, fifo_full, last_row, settled;

    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign fifo_full = (count == CW'(FIFO_DEPTH));
    assign last_row  = (row_index == 32'(N - 1));
    assign settled   = (settle_cnt == SW'(SETTLE - 1));

    assign busy      = (state == S_ISSUE) || (state == S_CAPTURE) || (state == S_DRAIN);
    assign mul_hold  = !((state == S_ISSUE) || (state == S_CAPTURE));
    assign done      = (state == S_DONE);
    assign state_dbg = state;
    assign out_data  = mem_data[rd_ptr];
    assign out_row   = mem_row[rd_ptr];

    always_comb begin
        state_nx = state;
        push     = 1'b0;
        case (state)
            S_IDLE:    if (start) state_nx = S_ISSUE;
            S_ISSUE:   if (settled) state_nx = S_CAPTURE;
            S_CAPTURE: begin
                // A pop in the same cycle frees a slot, so a full FIFO need not stall.
                if (!fifo_full || pop) begin
                    push     = 1'b1;
                    state_nx = last_row ? S_DRAIN : S_ISSUE;
                end
            end
            S_DRAIN: begin
                if ((count == '0) || ((count == CW'(1)) && pop)) state_nx = S_DONE;
            end
            S_DONE:    state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            settle_cnt <= '0;
            row_index  <= '0;
        end else begin
            state <= state_nx;
            if ((state == S_ISSUE) && !settled) settle_cnt <= settle_cnt + 1'b1;
            else                                settle_cnt <= '0;
            if ((state == S_IDLE) && start)     row_index <= '0;
            else if (push && !last_row)         row_index <= row_index + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_row[i]  <= '0;
            end
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= row_output;
                mem_row[wr_ptr]  <= row_index;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_spmv_row_sequencer.sv
// Scoreboard bench for spmv_row_sequencer: a default (N=4) instance and an N=6 instance
// used to reach the full-FIFO push/pop case.
module tb_spmv_row_sequencer;

    localparam logic [31:0] ST_IDLE = 32'd0, ST_ISSUE = 32'd1, ST_CAPTURE = 32'd2, ST_DRAIN = 32'd3;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        start, out_ready, mul_hold, out_valid, busy, done;
    logic [31:0] row_index, row_output, out_data, out_row;
    logic [2:0]  state_dbg;

    logic        start_b, out_ready_b, mul_hold_b, out_valid_b, busy_b, done_b;
    logic [31:0] row_index_b, row_output_b, out_data_b, out_row_b;
    logic [2:0]  state_dbg_b;

    bit neg_row1 = 1'b0;

    // combinational multiplier stand-ins
    assign row_output   = (neg_row1 && row_index == 32'd1) ? -32'sd7 : (row_index + 32'd1) * 32'd10;
    assign row_output_b = (row_index_b + 32'd1) * 32'd10;

    spmv_row_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .row_index(row_index), .mul_hold(mul_hold),
        .row_output(row_output), .out_data(out_data), .out_row(out_row), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    spmv_row_sequencer #(.N(6)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .row_index(row_index_b), .mul_hold(mul_hold_b),
        .row_output(row_output_b), .out_data(out_data_b), .out_row(out_row_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .busy(busy_b), .done(done_b), .state_dbg(state_dbg_b)
    );

    int checks = 0;
    int errors = 0;
    int done_count = 0;
    int done_count_b = 0;
    logic [31:0] exp_q[$], exp_row_q[$];
    logic [31:0] exp_b_q[$], exp_row_b_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard monitors
    always @(negedge clk) begin
        if (rst) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_beat: got row %0d data %0h expected no beat", out_row, out_data);
                end else begin
                    check("beat_row", out_row, exp_row_q.pop_front());
                    check("beat_data", out_data, exp_q.pop_front());
                end
            end
            if (done) begin
                done_count++;
                check("done_after_last_beat", 32'(exp_q.size()), 32'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (out_valid_b && out_ready_b) begin
                if (exp_b_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_beat_b: got row %0d data %0h expected no beat", out_row_b, out_data_b);
                end else begin
                    check("beat_row_b", out_row_b, exp_row_b_q.pop_front());
                    check("beat_data_b", out_data_b, exp_b_q.pop_front());
                end
            end
            if (done_b) begin
                done_count_b++;
                check("done_after_last_beat_b", 32'(exp_b_q.size()), 32'd0);
            end
        end
    end

    // driver tasks
    task automatic expect_beat(input logic [31:0] r, input logic [31:0] d);
        exp_row_q.push_back(r);
        exp_q.push_back(d);
    endtask

    task automatic pulse_start(input bit b);
        @(posedge clk); #1;
        if (b) start_b = 1'b1; else start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done(input bit b, input int budget);
        int c0;
        bit seen;
        c0 = b ? done_count_b : done_count;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk); #1;
            if ((b ? done_count_b : done_count) != c0) seen = 1'b1;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no done pulse expected one within %0d cycles", budget);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int  dc;
        bit  hit;
        rst = 1'b0; start = 1'b0; out_ready = 1'b1; start_b = 1'b0; out_ready_b = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // reset state
        @(negedge clk);
        check("rst_state", 32'(state_dbg), ST_IDLE);
        check("rst_row_index", row_index, 32'd0);
        check("rst_mul_hold", 32'(mul_hold), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_row", out_row, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);

        // T1: plain pass, consumer always ready
        expect_beat(0, 10); expect_beat(1, 20); expect_beat(2, 30); expect_beat(3, 40);
        pulse_start(0);
        @(negedge clk);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_mul_hold", 32'(mul_hold), 32'd0);
        wait_done(0, 100);
        check("t1_done_count", 32'(done_count), 32'd1);
        check("t1_idle_busy", 32'(busy), 32'd0);

        // T2: consumer stalled for 20 cycles
        @(posedge clk); #1 out_ready = 1'b0;
        expect_beat(0, 10); expect_beat(1, 20); expect_beat(2, 30); expect_beat(3, 40);
        pulse_start(0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("t2_row_index", row_index, 32'd3);
        check("t2_out_data_held", out_data, 32'd10);
        check("t2_out_row_held", out_row, 32'd0);
        check("t2_out_valid", 32'(out_valid), 32'd1);
        check("t2_state_drain", 32'(state_dbg), ST_DRAIN);
        check("t2_mul_hold", 32'(mul_hold), 32'd1);
        @(posedge clk); #1 out_ready = 1'b1;
        wait_done(0, 100);
        check("t2_done_count", 32'(done_count), 32'd2);

        // T6: negative multiplier result passes through bit-exact
        neg_row1 = 1'b1;
        expect_beat(0, 10); expect_beat(1, 32'hFFFF_FFF9); expect_beat(2, 30); expect_beat(3, 40);
        pulse_start(0);
        wait_done(0, 100);
        neg_row1 = 1'b0;
        check("t6_done_count", 32'(done_count), 32'd3);

        // T5: second start while busy is ignored
        expect_beat(0, 10); expect_beat(1, 20); expect_beat(2, 30); expect_beat(3, 40);
        pulse_start(0);
        repeat (3) @(posedge clk);
        pulse_start(0);
        wait_done(0, 100);
        check("t5_done_count", 32'(done_count), 32'd4);
        repeat (10) @(negedge clk);
        check("t5_no_extra_done", 32'(done_count), 32'd4);
        check("t5_state_idle", 32'(state_dbg), ST_IDLE);
        check("t5_no_extra_valid", 32'(out_valid), 32'd0);

        // T3: FIFO full in CAPTURE with a pop in the same cycle (N=6 instance)
        for (int r = 0; r < 6; r++) begin
            exp_row_b_q.push_back(32'(r));
            exp_b_q.push_back(32'((r + 1) * 10));
        end
        @(posedge clk); #1 out_ready_b = 1'b0;
        pulse_start(1);
        hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            @(posedge clk); #1;
            if (32'(state_dbg_b) == ST_CAPTURE && row_index_b == 32'd4) hit = 1'b1;
        end
        check("t3_reached_full_capture", 32'(hit), 32'd1);
        repeat (3) @(negedge clk);
        check("t3_stall_row_index", row_index_b, 32'd4);
        check("t3_stall_state", 32'(state_dbg_b), ST_CAPTURE);
        check("t3_stall_out_data", out_data_b, 32'd10);
        @(posedge clk); #1 out_ready_b = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t3_push_row_index", row_index_b, 32'd5);
        check("t3_push_state", 32'(state_dbg_b), ST_ISSUE);
        check("t3_pop_out_data", out_data_b, 32'd20);
        check("t3_pop_out_row", out_row_b, 32'd1);
        wait_done(1, 100);
        check("t3_done_count", 32'(done_count_b), 32'd1);

        // T4: reset mid-pass while row_index == 2
        expect_beat(0, 10); expect_beat(1, 20); expect_beat(2, 30); expect_beat(3, 40);
        pulse_start(0);
        hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            @(posedge clk); #1;
            if (row_index == 32'd2) hit = 1'b1;
        end
        check("t4_reached_row2", 32'(hit), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        exp_q.delete();
        exp_row_q.delete();
        dc = done_count;
        @(negedge clk);
        check("t4_state_idle", 32'(state_dbg), ST_IDLE);
        check("t4_out_valid", 32'(out_valid), 32'd0);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_row_index", row_index, 32'd0);
        check("t4_mul_hold", 32'(mul_hold), 32'd1);
        repeat (10) @(negedge clk);
        check("t4_no_done", 32'(done_count), 32'(dc));

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        check("final_queue_b_empty", 32'(exp_b_q.size()), 32'd0);

        // final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
